// File: rtl/cr_kme_unpack_pkg.sv
// Shared constants, entry layout and FSM states for the KME FIFO unpacker.
package cr_kme_unpack_pkg;

  localparam int KME_ENTRY_W   = 132;
  localparam int KME_DATA_W    = 128;
  localparam int KME_BEAT_W    = 32;
  localparam int KME_NUM_BEATS = KME_DATA_W / KME_BEAT_W;

  typedef struct packed {
    logic [1:0]            entry_type;
    logic                  eot;
    logic                  sot;
    logic [KME_DATA_W-1:0] data;
  } kme_entry_t;

  typedef enum logic {
    IDLE,
    SEND
  } unpack_state_e;

endpackage

// File: rtl/cr_kme_fifo_unpacker.sv
// Pops 132-bit KME FIFO entries and serialises each 128-bit payload into
// four 32-bit beats (LSB word first) with sot/eot/type/last sideband.
module cr_kme_fifo_unpacker
  import cr_kme_unpack_pkg::*;
#(
  parameter int IN_WIDTH   = KME_ENTRY_W,
  parameter int DATA_WIDTH = KME_DATA_W,
  parameter int BEAT_WIDTH = KME_BEAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   fifo_out,
  input  logic                  fifo_out_valid,
  output logic                  fifo_out_ack,
  output logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic                  beat_sot,
  output logic                  beat_eot,
  output logic [1:0]            beat_type,
  output logic                  beat_last,
  output logic                  busy
);

  localparam int NUM_BEATS = DATA_WIDTH / BEAT_WIDTH;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  localparam int SOT_POS  = DATA_WIDTH;
  localparam int EOT_POS  = DATA_WIDTH + 1;
  localparam int TYPE_LSB = DATA_WIDTH + 2;

  unpack_state_e state, state_next;
  logic [IN_WIDTH-1:0] hold;
  logic [IDX_W-1:0]    beat_idx;
  logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] hold_words;
  logic at_last;
  logic take;

  assign hold_words = hold[DATA_WIDTH-1:0];
  assign at_last    = (state == SEND) && (beat_idx == LAST_IDX);

  // Pop on an idle slot, or chain straight into the next entry as the last beat leaves.
  assign take = fifo_out_valid && !rst &&
                ((state == IDLE) || (at_last && beat_ready));
  assign fifo_out_ack = take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      beat_idx <= '0;
    end else if (take) begin
      hold     <= fifo_out;
      beat_idx <= '0;
    end else if ((state == SEND) && beat_ready && (beat_idx != LAST_IDX)) begin
      beat_idx <= beat_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (at_last && beat_ready) begin
          state_next = fifo_out_valid ? SEND : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sideband is gated by SEND so a finished entry left in the holding register stays invisible.
  always_comb begin
    beat_valid = 1'b0;
    beat_data  = '0;
    beat_sot   = 1'b0;
    beat_eot   = 1'b0;
    beat_type  = 2'b00;
    beat_last  = 1'b0;
    busy       = 1'b0;
    if (state == SEND) begin
      beat_valid = 1'b1;
      beat_data  = hold_words[beat_idx];
      beat_sot   = hold[SOT_POS] && (beat_idx == '0);
      beat_eot   = hold[EOT_POS] && (beat_idx == LAST_IDX);
      beat_type  = hold[TYPE_LSB +: 2];
      beat_last  = (beat_idx == LAST_IDX);
      busy       = 1'b1;
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_unpacker.sv
// Self-checking bench: an unbounded FIFO model feeds the unpacker and a
// compare process checks every beat against the entries in push order.
module tb_cr_kme_fifo_unpacker;
  import cr_kme_unpack_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [KME_ENTRY_W-1:0] fifo_out;
  logic                  fifo_out_valid;
  logic                  fifo_out_ack;
  logic [KME_BEAT_W-1:0] beat_data;
  logic                  beat_valid;
  logic                  beat_ready;
  logic                  beat_sot;
  logic                  beat_eot;
  logic [1:0]            beat_type;
  logic                  beat_last;
  logic                  busy;

  cr_kme_fifo_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_out       (fifo_out),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ack   (fifo_out_ack),
    .beat_data      (beat_data),
    .beat_valid     (beat_valid),
    .beat_ready     (beat_ready),
    .beat_sot       (beat_sot),
    .beat_eot       (beat_eot),
    .beat_type      (beat_type),
    .beat_last      (beat_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  kme_entry_t entries[$];
  int  rd_ptr = 0;
  logic ack_s;

  int exp_entry = 0;
  int exp_word  = 0;
  int compared   = 0;
  int mismatched = 0;
  int phase = 0;
  int timeouts = 0;
  int seen_timeouts = 0;
  kme_entry_t e;

  // FIFO model: head is entries[rd_ptr]; a pop is the ack seen just before the edge.
  initial begin
    ack_s          = 1'b0;
    fifo_out_valid = 1'b0;
    fifo_out       = '0;
    forever begin
      @(negedge clk);
      ack_s = fifo_out_ack && fifo_out_valid;
      @(posedge clk);
      if (ack_s) rd_ptr++;
      #2;
      fifo_out_valid = (rd_ptr < entries.size());
      fifo_out       = fifo_out_valid ? entries[rd_ptr] : '0;
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: model expectation is entry exp_entry, word exp_word.
  always @(negedge clk) begin
    if (rst) begin
      check_output("reset_outputs",
                   {beat_valid, beat_sot, beat_eot, beat_last, busy, fifo_out_ack, beat_type, beat_data},
                   '0);
      exp_entry = rd_ptr;
      exp_word  = 0;
    end else begin
      if (fifo_out_ack && !fifo_out_valid) check_output("underflow", 1, 0);
      if (beat_valid) begin
        if (exp_entry >= entries.size()) begin
          check_output("spurious_beat", {1'b1, beat_data}, 0);
        end else begin
          e = entries[exp_entry];
          check_output("beat_data", beat_data, e.data[exp_word*32 +: 32]);
          check_output("beat_sot", beat_sot, e.sot && (exp_word == 0));
          check_output("beat_eot", beat_eot, e.eot && (exp_word == 3));
          check_output("beat_type", beat_type, e.entry_type);
          check_output("beat_last", beat_last, exp_word == 3);
          check_output("busy_send", busy, 1);
          if (phase == 1) begin
            check_output("lit_single_data", beat_data, 32'h11111111 * exp_word);
            check_output("lit_single_type", beat_type, 2'b10);
          end
          if (phase == 3 && !beat_ready) check_output("lit_stall_word2", beat_data, 32'hCAFE0002);
          if (phase == 5) check_output("lit_post_reset", beat_data[31:16], 16'hBBBB);
          if (!beat_ready) begin
            check_output("stall_no_pop", fifo_out_ack, 0);
          end else if (exp_word == 3) begin
            check_output("chain_pop", fifo_out_ack, fifo_out_valid);
          end
          if (beat_ready) begin
            exp_word++;
            if (exp_word == 4) begin
              exp_word = 0;
              exp_entry++;
            end
          end
        end
      end else begin
        check_output("busy_idle", busy, 0);
        check_output("idle_pop", fifo_out_ack, fifo_out_valid);
        check_output("no_bubble", exp_entry < rd_ptr, 0);
      end
    end
    if (timeouts != seen_timeouts) begin
      check_output("wait_timeout", timeouts, seen_timeouts);
      seen_timeouts = timeouts;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [127:0] d, input logic sot, input logic eot, input logic [1:0] t);
    kme_entry_t n;
    n.data = d;
    n.sot = sot;
    n.eot = eot;
    n.entry_type = t;
    entries.push_back(n);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_entry < entries.size() && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) timeouts++;
  endtask

  task automatic wait_word(input int entry_idx, input int word, input int budget);
    int n = 0;
    while (!(exp_entry == entry_idx && exp_word == word) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) timeouts++;
  endtask

  initial begin
    int duty;
    int n;
    int idx;
    rst = 1'b1;
    beat_ready = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    $display("[TB] single entry");
    phase = 1;
    beat_ready = 1'b1;
    apply_stimulus(128'h33333333_22222222_11111111_00000000, 1'b1, 1'b1, 2'b10);
    drain(20);
    cycle();
    phase = 0;

    $display("[TB] back-to-back");
    apply_stimulus(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b1, 1'b0, 2'b01);
    apply_stimulus(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1'b0, 1'b0, 2'b11);
    apply_stimulus(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 1'b0, 1'b1, 2'b00);
    drain(30);
    cycle();

    $display("[TB] backpressure");
    phase = 3;
    idx = entries.size();
    apply_stimulus(128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 1'b1, 1'b1, 2'b01);
    apply_stimulus(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 1'b1, 1'b0, 2'b10);
    wait_word(idx, 2, 20);
    beat_ready = 1'b0;
    repeat (5) cycle();
    beat_ready = 1'b1;
    drain(30);
    phase = 0;

    $display("[TB] empty fifo");
    for (int i = 0; i < 20; i++) begin
      beat_ready = i[0];
      cycle();
    end

    $display("[TB] reset mid-entry");
    beat_ready = 1'b1;
    idx = entries.size();
    apply_stimulus(128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 1'b1, 1'b1, 2'b11);
    apply_stimulus(128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000, 1'b1, 1'b1, 2'b01);
    wait_word(idx, 2, 20);
    rst = 1'b1;
    repeat (2) cycle();
    phase = 5;
    rst = 1'b0;
    drain(20);
    cycle();
    phase = 0;

    $display("[TB] random traffic");
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom), 2'($urandom));
    end
    n = 0;
    duty = 100;
    while (exp_entry < entries.size() && n < 20000) begin
      if (n % 200 == 0) duty = $urandom_range(100, 30);
      beat_ready = ($urandom_range(99, 0) < duty);
      cycle();
      n++;
    end
    if (n >= 20000) timeouts++;
    beat_ready = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
